// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A bus front end.
// Initialization sequence states and command-word bit indices.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT = 3'd0,
        ICW2   = 3'd1,
        ICW3   = 3'd2,
        ICW4   = 3'd3,
        READY  = 3'd4
    } pic_state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_D3    = 3;
    localparam int CMD_D4    = 4;

    // Readback source: IMR on A0=1, otherwise ISR only when explicitly selected.
    function automatic logic [7:0] read_select(
        input logic       a0,
        input logic       en_read_reg,
        input logic       isr_or_irr,
        input logic [7:0] imr,
        input logic [7:0] isr,
        input logic [7:0] irr
    );
        if (a0)
            return imr;
        else if (en_read_reg && isr_or_irr)
            return isr;
        else
            return irr;
    endfunction

endpackage

// File: rtl/pic_bus_sync.sv
// Four-bit two-flop synchronizer for the CPU bus control pins.
// RESET_VAL lets idle-high strobes come out of reset inactive.
module pic_bus_sync #(
    parameter logic [3:0] RESET_VAL = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pic_bus_control_logic.sv
// CPU bus front end of the 8259A: write decode into ICW/OCW strobes and register readback.
// Define PIC_BUS_SYNC_EN to pass CS_N/WR_N/RD_N/A0 through a two-flop synchronizer.
module pic_bus_control_logic
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       CS_N,
    input  logic       WR_N,
    input  logic       RD_N,
    input  logic       A0,
    input  logic [7:0] DATA_IN,
    input  logic       EN_READ_REG,
    input  logic       READ_REG_ISR_OR_IRR,
    input  logic [7:0] ISR,
    input  logic [7:0] IRR,
    input  logic [7:0] IMR,
    output logic [7:0] internal_data_bus,
    output logic       write_ICW_1,
    output logic       write_ICW_2_4,
    output logic       write_OCW_1,
    output logic       write_OCW_2,
    output logic       write_OCW_3,
    output logic       INIT_DONE,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE
);

    logic s_cs_n, s_wr_n, s_rd_n, s_a0;
    logic p_cs_n, p_wr_n;
    logic a0_latched;
    logic commit;
    logic read_active;

    pic_state_t state, next_state;
    logic sngl, next_sngl;
    logic ic4, next_ic4;
    logic next_icw_1, next_icw_2_4, next_ocw_1, next_ocw_2, next_ocw_3;

`ifdef PIC_BUS_SYNC_EN
    logic [3:0] sync_q;

    pic_bus_sync #(
        .RESET_VAL(4'b1110)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     ({CS_N, WR_N, RD_N, A0}),
        .q     (sync_q)
    );

    assign {s_cs_n, s_wr_n, s_rd_n, s_a0} = sync_q;
`else
    assign s_cs_n = CS_N;
    assign s_wr_n = WR_N;
    assign s_rd_n = RD_N;
    assign s_a0   = A0;
`endif

    // Previous-cycle pin values; idle-high so reset never looks like a WR_N rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_cs_n <= 1'b1;
            p_wr_n <= 1'b1;
        end else begin
            p_cs_n <= s_cs_n;
            p_wr_n <= s_wr_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            internal_data_bus <= 8'h00;
            a0_latched        <= 1'b0;
        end else if (!s_cs_n && !s_wr_n) begin
            internal_data_bus <= DATA_IN;
            a0_latched        <= s_a0;
        end
    end

    assign commit      = !p_wr_n && s_wr_n && !p_cs_n;
    assign read_active = !s_cs_n && !s_rd_n && s_wr_n;

    // Command decode on the WR_N rising edge; ICW1 is recognised in every state.
    always_comb begin
        next_state   = state;
        next_sngl    = sngl;
        next_ic4     = ic4;
        next_icw_1   = 1'b0;
        next_icw_2_4 = 1'b0;
        next_ocw_1   = 1'b0;
        next_ocw_2   = 1'b0;
        next_ocw_3   = 1'b0;
        if (commit) begin
            if (!a0_latched && internal_data_bus[CMD_D4]) begin
                next_icw_1 = 1'b1;
                next_sngl  = internal_data_bus[ICW1_SNGL];
                next_ic4   = internal_data_bus[ICW1_IC4];
                next_state = ICW2;
            end else begin
                case (state)
                    ICW2: begin
                        if (a0_latched) begin
                            next_icw_2_4 = 1'b1;
                            if (!sngl)
                                next_state = ICW3;
                            else if (ic4)
                                next_state = ICW4;
                            else
                                next_state = READY;
                        end
                    end
                    ICW3: begin
                        if (a0_latched) begin
                            next_icw_2_4 = 1'b1;
                            next_state   = ic4 ? ICW4 : READY;
                        end
                    end
                    ICW4: begin
                        if (a0_latched) begin
                            next_icw_2_4 = 1'b1;
                            next_state   = READY;
                        end
                    end
                    READY: begin
                        if (a0_latched)
                            next_ocw_1 = 1'b1;
                        else if (internal_data_bus[CMD_D4:CMD_D3] == 2'b00)
                            next_ocw_2 = 1'b1;
                        else if (internal_data_bus[CMD_D4:CMD_D3] == 2'b01)
                            next_ocw_3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= UNINIT;
            sngl          <= 1'b0;
            ic4           <= 1'b0;
            write_ICW_1   <= 1'b0;
            write_ICW_2_4 <= 1'b0;
            write_OCW_1   <= 1'b0;
            write_OCW_2   <= 1'b0;
            write_OCW_3   <= 1'b0;
        end else begin
            state         <= next_state;
            sngl          <= next_sngl;
            ic4           <= next_ic4;
            write_ICW_1   <= next_icw_1;
            write_ICW_2_4 <= next_icw_2_4;
            write_OCW_1   <= next_ocw_1;
            write_OCW_2   <= next_ocw_2;
            write_OCW_3   <= next_ocw_3;
        end
    end

    assign INIT_DONE = (state == READY);

    // A simultaneous write masks the read, and DATA_OUT keeps the last value read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            DATA_OE  <= 1'b0;
            DATA_OUT <= 8'h00;
        end else begin
            DATA_OE <= read_active;
            if (read_active)
                DATA_OUT <= read_select(s_a0, EN_READ_REG, READ_REG_ISR_OR_IRR,
                                        IMR, ISR, IRR);
        end
    end

endmodule

// File: tb/tb_pic_bus_control_logic.sv
// Directed self-checking bench for pic_bus_control_logic (default build, raw pins).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pic_bus_control_logic;

    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_ICW1  = 5'b10000;
    localparam logic [4:0] S_ICW24 = 5'b01000;
    localparam logic [4:0] S_OCW1  = 5'b00100;
    localparam logic [4:0] S_OCW2  = 5'b00010;
    localparam logic [4:0] S_OCW3  = 5'b00001;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       CS_N = 1'b1, WR_N = 1'b1, RD_N = 1'b1, A0 = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       EN_READ_REG = 1'b0, READ_REG_ISR_OR_IRR = 1'b0;
    logic [7:0] ISR = 8'h00, IRR = 8'h00, IMR = 8'h00;
    logic [7:0] internal_data_bus;
    logic       write_ICW_1, write_ICW_2_4, write_OCW_1, write_OCW_2, write_OCW_3;
    logic       INIT_DONE;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic [4:0] strobes;

    int errors = 0;
    int checks = 0;

    pic_bus_control_logic dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .CS_N                (CS_N),
        .WR_N                (WR_N),
        .RD_N                (RD_N),
        .A0                  (A0),
        .DATA_IN             (DATA_IN),
        .EN_READ_REG         (EN_READ_REG),
        .READ_REG_ISR_OR_IRR (READ_REG_ISR_OR_IRR),
        .ISR                 (ISR),
        .IRR                 (IRR),
        .IMR                 (IMR),
        .internal_data_bus   (internal_data_bus),
        .write_ICW_1         (write_ICW_1),
        .write_ICW_2_4       (write_ICW_2_4),
        .write_OCW_1         (write_OCW_1),
        .write_OCW_2         (write_OCW_2),
        .write_OCW_3         (write_OCW_3),
        .INIT_DONE           (INIT_DONE),
        .DATA_OUT            (DATA_OUT),
        .DATA_OE             (DATA_OE)
    );

    assign strobes = {write_ICW_1, write_ICW_2_4, write_OCW_1, write_OCW_2, write_OCW_3};

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        CS_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1; A0 = 1'b0; DATA_IN = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One write cycle; returns strobes in the commit cycle and the cycle after.
    task automatic do_write(input logic a, input logic [7:0] d,
                            output logic [4:0] strb, output logic [4:0] strb_after,
                            output logic init_at);
        @(negedge clk);
        CS_N = 1'b0; WR_N = 1'b0; A0 = a; DATA_IN = d;
        @(negedge clk);
        CS_N = 1'b1; WR_N = 1'b1;
        @(negedge clk);
        strb    = strobes;
        init_at = INIT_DONE;
        @(negedge clk);
        strb_after = strobes;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (internal_data_bus !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_idb: got %h expected 00", internal_data_bus);
        end
        checks++;
        if (strobes !== S_NONE) begin
            errors++; $display("[TB] FAIL reset_strobes: got %b expected %b", strobes, S_NONE);
        end
        checks++;
        if (INIT_DONE !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_init_done: got %b expected 0", INIT_DONE);
        end
        checks++;
        if (DATA_OUT !== 8'h00 || DATA_OE !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_read: got out=%h oe=%b expected out=00 oe=0", DATA_OUT, DATA_OE);
        end
    endtask

    // Table rows: {a0, data, expected strobe, expected INIT_DONE at the strobe cycle}.
    task automatic test_icw_sequence();
        logic [14:0] tbl [4];
        logic [4:0] st, st_after;
        logic init_at;
        tbl = '{{1'b0, 8'h0B, S_NONE,  1'b0},
                {1'b0, 8'h1B, S_ICW1,  1'b0},
                {1'b1, 8'hA8, S_ICW24, 1'b0},
                {1'b1, 8'h03, S_ICW24, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            do_write(tbl[i][14], tbl[i][13:6], st, st_after, init_at);
            checks++;
            if (st !== tbl[i][5:1]) begin
                errors++; $display("[TB] FAIL icw_strobe[%0d]: got %b expected %b", i, st, tbl[i][5:1]);
            end
            checks++;
            if (st_after !== S_NONE) begin
                errors++; $display("[TB] FAIL icw_strobe_width[%0d]: got %b expected %b", i, st_after, S_NONE);
            end
            checks++;
            if (init_at !== tbl[i][0]) begin
                errors++; $display("[TB] FAIL icw_init_done[%0d]: got %b expected %b", i, init_at, tbl[i][0]);
            end
        end
        checks++;
        if (internal_data_bus !== 8'h03) begin
            errors++; $display("[TB] FAIL icw_idb: got %h expected 03", internal_data_bus);
        end
    endtask

    task automatic test_ocw();
        logic [14:0] tbl [3];
        logic [4:0] st, st_after;
        logic init_at;
        tbl = '{{1'b1, 8'h00, S_OCW1, 1'b1},
                {1'b0, 8'h00, S_OCW2, 1'b1},
                {1'b0, 8'h08, S_OCW3, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            do_write(tbl[i][14], tbl[i][13:6], st, st_after, init_at);
            checks++;
            if (st !== tbl[i][5:1]) begin
                errors++; $display("[TB] FAIL ocw_strobe[%0d]: got %b expected %b", i, st, tbl[i][5:1]);
            end
            checks++;
            if (st_after !== S_NONE) begin
                errors++; $display("[TB] FAIL ocw_strobe_width[%0d]: got %b expected %b", i, st_after, S_NONE);
            end
            checks++;
            if (init_at !== tbl[i][0]) begin
                errors++; $display("[TB] FAIL ocw_init_done[%0d]: got %b expected %b", i, init_at, tbl[i][0]);
            end
        end
    endtask

    // Restart from READY with cascade+IC4 (three ICW2-4), then single without IC4 (one).
    task automatic test_cascade();
        logic [14:0] tbl [7];
        logic [4:0] st, st_after;
        logic init_at;
        tbl = '{{1'b0, 8'h19, S_ICW1,  1'b0},
                {1'b0, 8'h00, S_NONE,  1'b0},
                {1'b1, 8'hAA, S_ICW24, 1'b0},
                {1'b1, 8'hBB, S_ICW24, 1'b0},
                {1'b1, 8'hCC, S_ICW24, 1'b1},
                {1'b0, 8'h12, S_ICW1,  1'b0},
                {1'b1, 8'hDD, S_ICW24, 1'b1}};
        for (int i = 0; i < 7; i++) begin
            do_write(tbl[i][14], tbl[i][13:6], st, st_after, init_at);
            checks++;
            if (st !== tbl[i][5:1]) begin
                errors++; $display("[TB] FAIL cascade_strobe[%0d]: got %b expected %b", i, st, tbl[i][5:1]);
            end
            checks++;
            if (init_at !== tbl[i][0]) begin
                errors++; $display("[TB] FAIL cascade_init_done[%0d]: got %b expected %b", i, init_at, tbl[i][0]);
            end
        end
    endtask

    // Rows: {a0, en_read_reg, isr_or_irr, expected DATA_OUT}.
    task automatic test_read();
        logic [10:0] tbl [4];
        logic [4:0] st;
        IMR = 8'h5A; ISR = 8'h04; IRR = 8'h02;
        tbl = '{{1'b1, 1'b0, 1'b0, 8'h5A},
                {1'b0, 1'b1, 1'b1, 8'h04},
                {1'b0, 1'b1, 1'b0, 8'h02},
                {1'b0, 1'b0, 1'b1, 8'h02}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            CS_N = 1'b0; RD_N = 1'b0; A0 = tbl[i][10];
            EN_READ_REG = tbl[i][9]; READ_REG_ISR_OR_IRR = tbl[i][8];
            @(negedge clk);
            checks++;
            if (DATA_OE !== 1'b1 || DATA_OUT !== tbl[i][7:0]) begin
                errors++; $display("[TB] FAIL read[%0d]: got oe=%b out=%h expected oe=1 out=%h", i, DATA_OE, DATA_OUT, tbl[i][7:0]);
            end
            CS_N = 1'b1; RD_N = 1'b1;
            @(negedge clk);
            checks++;
            if (DATA_OE !== 1'b0 || DATA_OUT !== tbl[i][7:0]) begin
                errors++; $display("[TB] FAIL read_hold[%0d]: got oe=%b out=%h expected oe=0 out=%h", i, DATA_OE, DATA_OUT, tbl[i][7:0]);
            end
        end
        @(negedge clk);
        CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b0; A0 = 1'b1; DATA_IN = 8'h77;
        @(negedge clk);
        checks++;
        if (DATA_OE !== 1'b0) begin
            errors++; $display("[TB] FAIL read_during_write_oe: got %b expected 0", DATA_OE);
        end
        CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
        @(negedge clk);
        st = strobes;
        checks++;
        if (st !== S_OCW1) begin
            errors++; $display("[TB] FAIL read_during_write_strobe: got %b expected %b", st, S_OCW1);
        end
        checks++;
        if (internal_data_bus !== 8'h77 || DATA_OUT !== 8'h02) begin
            errors++; $display("[TB] FAIL read_during_write_data: got idb=%h out=%h expected idb=77 out=02", internal_data_bus, DATA_OUT);
        end
    endtask

    task automatic test_uninit();
        logic [4:0] st, st_after;
        logic init_at;
        apply_reset();
        do_write(1'b0, 8'h00, st, st_after, init_at);
        checks++;
        if (st !== S_NONE || init_at !== 1'b0) begin
            errors++; $display("[TB] FAIL uninit_a0_0: got strb=%b init=%b expected strb=%b init=0", st, init_at, S_NONE);
        end
        do_write(1'b1, 8'hFF, st, st_after, init_at);
        checks++;
        if (st !== S_NONE || init_at !== 1'b0) begin
            errors++; $display("[TB] FAIL uninit_a0_1: got strb=%b init=%b expected strb=%b init=0", st, init_at, S_NONE);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] st, st_after;
        logic init_at;
        apply_reset();
        do_write(1'b0, 8'h19, st, st_after, init_at);
        do_write(1'b1, 8'h01, st, st_after, init_at);
        @(negedge clk);
        CS_N = 1'b0; WR_N = 1'b0; A0 = 1'b1; DATA_IN = 8'h44;
        @(negedge clk);
        reset_n = 1'b0; CS_N = 1'b1; WR_N = 1'b1;
        #1;
        checks++;
        if (internal_data_bus !== 8'h00 || strobes !== S_NONE || INIT_DONE !== 1'b0
            || DATA_OE !== 1'b0 || DATA_OUT !== 8'h00) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: got idb=%h strb=%b init=%b oe=%b out=%h expected all zero",
                               internal_data_bus, strobes, INIT_DONE, DATA_OE, DATA_OUT);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++; $display("[TB] FAIL mid_reset_discard: got %b expected %b", strobes, S_NONE);
        end
        do_write(1'b1, 8'h55, st, st_after, init_at);
        checks++;
        if (st !== S_NONE || init_at !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_uninit: got strb=%b init=%b expected strb=%b init=0", st, init_at, S_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_icw_sequence();
        test_ocw();
        test_cascade();
        test_read();
        test_uninit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
